fifo_sync: RTL and testbench

//   Single-clock synchronous FIFO, 16 entries x 8 bits, first-word-fall-through read.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ptr.sv | 29 ++
 rtl/fifo_sync.sv | 85 ++++++++
 tb/tb_fifo_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing for the synchronous FWFT FIFO: word width, depth, pointer
// width and the occupancy type.
package fifo_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  // Occupancy needs one bit more than a pointer so that 0 and DEPTH are distinct.
  typedef logic [AW:0] occ_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping AW-bit pointer for the FIFO. It advances by one on each enabled
// edge and wraps from 2**AW-1 back to 0.
module fifo_ptr #(
  parameter int AW = fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_d;
  logic [AW-1:0] ptr_q;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + AW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO. Writes are blocked while it is full
// and reads while it is empty, so overflow and underflow cannot corrupt state.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int DEPTH = fifo_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       ren,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] data_q [0:DEPTH-1];
  logic [PW:0]      count_d;
  logic [PW:0]      count_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wa;
  logic             ra;

  // A blocked request is simply not accepted; no other state sees it.
  assign wa = wen & ~full;
  assign ra = ren & ~empty;

  fifo_ptr #(.AW(PW)) fifo_writer (
    .clk (clk),
    .rst (rst),
    .en  (wa),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.AW(PW)) fifo_reader (
    .clk (clk),
    .rst (rst),
    .en  (ra),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (wa && !ra)      count_d = count_q + (PW+1)'(1);
    else if (ra && !wa) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // NOTE: storage is left unreset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wa) data_q[wr_ptr] <= wdata;
  end

  assign rdata = data_q[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

`ifdef FORMAL
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
    (count_q[PW-1:0] == PW'(wr_ptr - rd_ptr)) && (count_q <= (PW+1)'(DEPTH)));

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(full && empty));

  a_blocked_write: assert property (@(posedge clk) disable iff (rst)
    (wen && full) |=> (wr_ptr == $past(wr_ptr)));

  a_blocked_read: assert property (@(posedge clk) disable iff (rst)
    (ren && empty) |=> (rd_ptr == $past(rd_ptr)));

  c_reach_full: cover property (@(posedge clk) disable iff (rst) full);
`endif

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync: reset, FWFT latency, full/empty
// blocking, pointer wrap under simultaneous traffic, and asynchronous reset.
module tb_fifo_sync;
  import fifo_pkg::*;

  logic             clk;
  logic             rst;
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  occ_t             count;

  int n_cmp;
  int n_err;

  logic [7:0] fill_tbl [0:15] = '{8'h04, 8'h00, 8'h00, 8'h02, 8'h88, 8'h83, 8'h11, 8'h5a,
                                  8'ha5, 8'hff, 8'h7e, 8'hc3, 8'h3c, 8'h01, 8'h80, 8'h69};

  fifo_sync dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .wdata (wdata),
    .ren   (ren),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs are then changed and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wen = 1'b0; ren = 1'b0; wdata = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
    step();
    n_cmp++; if (count !== occ_t'(0)) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    rst = 1'b0;
    step(); step();
    n_cmp++; if (count !== occ_t'(0) || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL idle_state got count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
    ren = 1'b1;
    step();
    ren = 1'b0;
    n_cmp++; if (dut.rd_ptr !== 4'd0) begin n_err++; $display("FAIL underflow_rd_ptr got %0d want 0", dut.rd_ptr); end
    n_cmp++; if (count !== occ_t'(0) || empty !== 1'b1) begin
      n_err++; $display("FAIL underflow_count got count=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  task automatic test_single();
    wen = 1'b1; wdata = 8'h04;
    step();
    wen = 1'b0;
    n_cmp++; if (count !== occ_t'(1)) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
    n_cmp++; if (rdata !== 8'h04) begin n_err++; $display("FAIL single_fwft got %h want 04", rdata); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_not_empty got %b want 0", empty); end
    ren = 1'b1;
    step();
    ren = 1'b0;
    n_cmp++; if (count !== occ_t'(0) || empty !== 1'b1) begin
      n_err++; $display("FAIL single_drained got count=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = fill_tbl[i];
      step();
    end
    n_cmp++; if (full !== 1'b1 || count !== occ_t'(16)) begin
      n_err++; $display("FAIL fill_full got full=%b count=%0d want 1/16", full, count);
    end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_not_empty got %b want 0", empty); end
    wdata = 8'hee;
    step();
    wen = 1'b0;
    n_cmp++; if (dut.wr_ptr !== 4'd0) begin n_err++; $display("FAIL overflow_wr_ptr got %0d want 0", dut.wr_ptr); end
    n_cmp++; if (count !== occ_t'(16)) begin n_err++; $display("FAIL overflow_count got %0d want 16", count); end
    n_cmp++; if (rdata !== 8'h04) begin n_err++; $display("FAIL overflow_head got %h want 04", rdata); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rdata !== fill_tbl[i]) begin
        n_err++; $display("FAIL drain_order[%0d] got %h want %h", i, rdata, fill_tbl[i]);
      end
      ren = 1'b1;
      step();
    end
    n_cmp++; if (empty !== 1'b1 || count !== occ_t'(0)) begin
      n_err++; $display("FAIL drain_empty got empty=%b count=%0d want 1/0", empty, count);
    end
    step();
    ren = 1'b0;
    n_cmp++; if (count !== occ_t'(0) || dut.rd_ptr !== 4'd0) begin
      n_err++; $display("FAIL drain_extra_read got count=%0d rd_ptr=%0d want 0/0", count, dut.rd_ptr);
    end
  endtask

  // Stream values 0x10+n; pointers start at 0 here.
  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      wen = 1'b1; wdata = 8'h10 + 8'(n);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      n_cmp++; if (rdata !== 8'h10 + 8'(k)) begin
        n_err++; $display("FAIL b2b_order[%0d] got %h want %h", k, rdata, 8'h10 + 8'(k));
      end
      wen = 1'b1; ren = 1'b1; wdata = 8'h18 + 8'(k);
      step();
      n_cmp++; if (count !== occ_t'(8)) begin
        n_err++; $display("FAIL b2b_count[%0d] got %0d want 8", k, count);
      end
    end
    ren = 1'b0;
    n_cmp++; if (dut.wr_ptr !== 4'd12 || dut.rd_ptr !== 4'd4) begin
      n_err++; $display("FAIL b2b_wrap got wr=%0d rd=%0d want 12/4", dut.wr_ptr, dut.rd_ptr);
    end
    for (int n = 28; n < 36; n++) begin
      wen = 1'b1; wdata = 8'h10 + 8'(n);
      step();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL b2b_refull got %b want 1", full); end
    wen = 1'b1; ren = 1'b1; wdata = 8'hdd;
    step();
    wen = 1'b0; ren = 1'b0;
    n_cmp++; if (count !== occ_t'(15) || rdata !== 8'h25) begin
      n_err++; $display("FAIL full_wr_rd got count=%0d rdata=%h want 15/25", count, rdata);
    end
    ren = 1'b1;
    for (int i = 0; i < 15; i++) step();
    ren = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_drained got %b want 1", empty); end
    wen = 1'b1; ren = 1'b1; wdata = 8'hab;
    step();
    wen = 1'b0; ren = 1'b0;
    n_cmp++; if (count !== occ_t'(1) || rdata !== 8'hab) begin
      n_err++; $display("FAIL empty_wr_rd got count=%0d rdata=%h want 1/ab", count, rdata);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = 8'h30 + 8'(i);
      step();
    end
    wen = 1'b0;
    n_cmp++; if (count !== occ_t'(5)) begin n_err++; $display("FAIL pre_reset_count got %0d want 5", count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (count !== occ_t'(0) || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL async_reset got count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
    #2 rst = 1'b0;
    step();
    n_cmp++; if (count !== occ_t'(0)) begin n_err++; $display("FAIL post_reset_idle got %0d want 0", count); end
    wen = 1'b1; wdata = 8'h5c;
    step();
    wen = 1'b0;
    n_cmp++; if (count !== occ_t'(1) || rdata !== 8'h5c) begin
      n_err++; $display("FAIL post_reset_write got count=%0d rdata=%h want 1/5c", count, rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_sync
